// File: rtl/tapped_shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
// Shared definitions for the tapped shift register:
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default chain geometry
//   POP_MAX                       : widest valid vector popcount() accepts
//   shift_dir_e                   : shift direction encoding of the dir port
//   popcount()                    : number of set bits, used for fillCount
// -----------------------------------------------------------------------------
package shift_register_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 8;

  // popcount() works on a fixed-width vector; chains up to this depth are
  // supported by zero-extending the valid bits into it.
  localparam int POP_MAX = 64;

  typedef enum logic {
    SHIFT_FWD = 1'b0,  // toward stage DEPTH-1
    SHIFT_REV = 1'b1   // toward stage 0
  } shift_dir_e;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tapped_shift_register_if.sv
// -----------------------------------------------------------------------------
// tapped_shift_register_if
// Bundles the control, data and status signals of tapped_shift_register.
// Parameters: DEPTH (stages), WIDTH (bits per word); SEL_W and CNT_W derived.
// Signals:
//   shiftEnable, dir, clear, rotate   control from the producer
//   wordIn, tapSel                    entry word and tap index
//   wordOut, wordValid                end-of-chain word and its valid bit
//   tapOut                            word at stage[tapSel]
//   fillCount, full                   occupancy status
// Modports: master drives the inputs, slave is the shift register itself.
// There is no ready/backpressure: every word presented with shiftEnable=1 is
// accepted on that edge; wordValid marks a live word at the exit, and the
// consumer is expected to take it before the next shift or lose it.
// -----------------------------------------------------------------------------
interface tapped_shift_register_if
  import shift_register_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
);

  logic             shiftEnable;
  logic             dir;
  logic             clear;
  logic             rotate;
  logic [WIDTH-1:0] wordIn;
  logic [SEL_W-1:0] tapSel;
  logic [WIDTH-1:0] wordOut;
  logic             wordValid;
  logic [WIDTH-1:0] tapOut;
  logic [CNT_W-1:0] fillCount;
  logic             full;

  modport master (
    output shiftEnable, dir, clear, rotate, wordIn, tapSel,
    input  wordOut, wordValid, tapOut, fillCount, full
  );

  modport slave (
    input  shiftEnable, dir, clear, rotate, wordIn, tapSel,
    output wordOut, wordValid, tapOut, fillCount, full
  );

endinterface

// File: rtl/tapped_shift_register_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One link of the chain: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clear          synchronous flush (same effect as reset)
//   load           capture d_next/v_next this edge
//   d_next, v_next next data and valid
//   d_q, v_q       registered data and valid
// -----------------------------------------------------------------------------
module shift_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d_next,
  input  logic             v_next,
  output logic [WIDTH-1:0] d_q,
  output logic             v_q
);

  logic [WIDTH:0] reg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q <= '0;
    end else if (clear) begin
      reg_q <= '0;
    end else if (load) begin
      reg_q <= {v_next, d_next};
    end
  end

  assign d_q = reg_q[WIDTH-1:0];
  assign v_q = reg_q[WIDTH];

endmodule

// File: rtl/tapped_shift_register.sv
// -----------------------------------------------------------------------------
// tapped_shift_register
// DEPTH-stage, WIDTH-bit word shift register with per-stage valid bits,
// bidirectional shift, synchronous clear, a combinational tap and a
// registered fill counter.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset (highest priority)
//   bus    tapped_shift_register_if.slave (see interface for signal list)
// Priority: reset > clear > shiftEnable > hold.
// Optional feature macro: SHREG_ROTATE_EN. When defined, rotate=1 with
// shiftEnable=1 feeds the exiting word (with its valid bit) back into the
// entry end; when undefined, rotate is ignored.
// -----------------------------------------------------------------------------
module tapped_shift_register
  import shift_register_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                    clk,
  input logic                    reset,
  tapped_shift_register_if.slave bus
);

  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  logic             rev_sel;
  logic             rotate_act;
  logic [WIDTH-1:0] entry_data;
  logic             entry_valid;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] tap_data;

  assign rev_sel = (shift_dir_e'(bus.dir) == SHIFT_REV);

`ifdef SHREG_ROTATE_EN
  assign rotate_act = bus.rotate;
`else
  assign rotate_act = 1'b0;
`endif

  // Word entering the chain. On a rotate it is the word about to fall off
  // the far end, so the chain occupancy cannot change.
  always_comb begin
    entry_data  = bus.wordIn;
    entry_valid = 1'b1;
    if (rotate_act) begin
      if (rev_sel) begin
        entry_data  = stage_q[0];
        entry_valid = valid_q[0];
      end else begin
        entry_data  = stage_q[DEPTH-1];
        entry_valid = valid_q[DEPTH-1];
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] fwd_d;
      logic [WIDTH-1:0] rev_d;
      logic             fwd_v;
      logic             rev_v;

      if (i == 0) begin : g_fwd_entry
        assign fwd_d = entry_data;
        assign fwd_v = entry_valid;
      end else begin : g_fwd_link
        assign fwd_d = stage_q[i-1];
        assign fwd_v = valid_q[i-1];
      end

      if (i == DEPTH - 1) begin : g_rev_entry
        assign rev_d = entry_data;
        assign rev_v = entry_valid;
      end else begin : g_rev_link
        assign rev_d = stage_q[i+1];
        assign rev_v = valid_q[i+1];
      end

      assign stage_d[i] = rev_sel ? rev_d : fwd_d;
      assign valid_d[i] = rev_sel ? rev_v : fwd_v;

      shift_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.clear),
        .load   (bus.shiftEnable),
        .d_next (stage_d[i]),
        .v_next (valid_d[i]),
        .d_q    (stage_q[i]),
        .v_q    (valid_q[i])
      );
    end
  endgenerate

  // Count is the popcount of the valid bits the stages are about to hold,
  // so it stays exactly in step with the chain without up/down bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (bus.clear) begin
      count_q <= '0;
    end else if (bus.shiftEnable) begin
      count_q <= CNT_W'(popcount(POP_MAX'(valid_d)));
    end
  end

  // Tap mux; indices past the last stage (non power-of-two DEPTH) read zero.
  always_comb begin
    tap_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.tapSel == SEL_W'(k)) begin
        tap_data = stage_q[k];
      end
    end
  end

  assign bus.wordOut   = stage_q[DEPTH-1];
  assign bus.wordValid = valid_q[DEPTH-1];
  assign bus.tapOut    = tap_data;
  assign bus.fillCount = count_q;
  assign bus.full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_tapped_shift_register.sv
// -----------------------------------------------------------------------------
// tb_tapped_shift_register
// Directed bench for tapped_shift_register at DEPTH=4, WIDTH=8.
// -----------------------------------------------------------------------------
module tb_tapped_shift_register;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  tapped_shift_register_if #(.DEPTH(4), .WIDTH(8)) bus ();

  tapped_shift_register #(
    .DEPTH (4),
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- drivers
  // Drive inputs, take one rising edge, return 1 time unit after it.
  task automatic drive(input logic sh, input logic d, input logic [7:0] w,
                       input logic clr, input logic rot);
    bus.shiftEnable = sh;
    bus.dir         = d;
    bus.wordIn      = w;
    bus.clear       = clr;
    bus.rotate      = rot;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    // Busy inputs during reset show that reset wins.
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    bus.shiftEnable = 1'b0;
    bus.wordIn      = 8'h00;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [7:0] got;
    apply_reset(2);
    vectors++;
    if (bus.wordOut !== 8'h00) begin
      $display("FAIL reset_wordOut: got %0h expected 00", bus.wordOut); miscompares++;
    end
    vectors++;
    if (bus.wordValid !== 1'b0) begin
      $display("FAIL reset_wordValid: got %0b expected 0", bus.wordValid); miscompares++;
    end
    vectors++;
    if (bus.fillCount !== 3'd0) begin
      $display("FAIL reset_fillCount: got %0d expected 0", bus.fillCount); miscompares++;
    end
    vectors++;
    if (bus.full !== 1'b0) begin
      $display("FAIL reset_full: got %0b expected 0", bus.full); miscompares++;
    end
    for (int t = 0; t < 4; t++) begin
      bus.tapSel = 2'(t);
      #1;
      got = bus.tapOut;
      vectors++;
      if (got !== 8'h00) begin
        $display("FAIL reset_tap%0d: got %0h expected 00", t, got); miscompares++;
      end
    end
  endtask

  task automatic test_forward_fill();
    logic [7:0] win      [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp_out  [5] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    logic       exp_val  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] exp_cnt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_full [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_tap  [4] = '{8'h55, 8'h44, 8'h33, 8'h22};
    apply_reset(2);
    for (int e = 0; e < 5; e++) begin
      drive(1'b1, 1'b0, win[e], 1'b0, 1'b0);
      vectors++;
      if (bus.wordOut !== exp_out[e]) begin
        $display("FAIL fwd_wordOut edge%0d: got %0h expected %0h", e + 1, bus.wordOut, exp_out[e]); miscompares++;
      end
      vectors++;
      if (bus.wordValid !== exp_val[e]) begin
        $display("FAIL fwd_wordValid edge%0d: got %0b expected %0b", e + 1, bus.wordValid, exp_val[e]); miscompares++;
      end
      vectors++;
      if (bus.fillCount !== exp_cnt[e]) begin
        $display("FAIL fwd_fillCount edge%0d: got %0d expected %0d", e + 1, bus.fillCount, exp_cnt[e]); miscompares++;
      end
      vectors++;
      if (bus.full !== exp_full[e]) begin
        $display("FAIL fwd_full edge%0d: got %0b expected %0b", e + 1, bus.full, exp_full[e]); miscompares++;
      end
    end
    bus.shiftEnable = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bus.tapSel = 2'(t);
      #1;
      vectors++;
      if (bus.tapOut !== exp_tap[t]) begin
        $display("FAIL fwd_tap%0d: got %0h expected %0h", t, bus.tapOut, exp_tap[t]); miscompares++;
      end
    end
  endtask

  task automatic test_gaps();
    apply_reset(1);
    drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    // Holds with junk on wordIn/dir/rotate must leave the chain alone.
    for (int h = 0; h < 3; h++) drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    vectors++;
    if (bus.fillCount !== 3'd1) begin
      $display("FAIL gap_hold_fillCount: got %0d expected 1", bus.fillCount); miscompares++;
    end
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, 8'hB0 + 8'(s), 1'b0, 1'b0);
      vectors++;
      if (s < 2 && bus.wordValid !== 1'b0) begin
        $display("FAIL gap_early_valid shift%0d: got %0b expected 0", s + 2, bus.wordValid); miscompares++;
      end else if (s == 2 && (bus.wordOut !== 8'hA1 || bus.wordValid !== 1'b1)) begin
        $display("FAIL gap_wordOut: got %0h/%0b expected a1/1", bus.wordOut, bus.wordValid); miscompares++;
      end
    end
  endtask

  task automatic test_reverse();
    apply_reset(1);
    drive(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0);
    vectors++;
    if (bus.wordOut !== 8'h5C || bus.wordValid !== 1'b1) begin
      $display("FAIL rev_wordOut: got %0h/%0b expected 5c/1", bus.wordOut, bus.wordValid); miscompares++;
    end
    vectors++;
    if (bus.fillCount !== 3'd1) begin
      $display("FAIL rev_fillCount: got %0d expected 1", bus.fillCount); miscompares++;
    end
    bus.tapSel = 2'd3; #1;
    vectors++;
    if (bus.tapOut !== 8'h5C) begin
      $display("FAIL rev_tap3: got %0h expected 5c", bus.tapOut); miscompares++;
    end
    bus.tapSel = 2'd0; #1;
    vectors++;
    if (bus.tapOut !== 8'h00) begin
      $display("FAIL rev_tap0: got %0h expected 00", bus.tapOut); miscompares++;
    end
    // Three more reverse shifts fill the chain; a fifth saturates.
    drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    vectors++;
    if (bus.fillCount !== 3'd4 || bus.full !== 1'b1) begin
      $display("FAIL rev_full: got %0d/%0b expected 4/1", bus.fillCount, bus.full); miscompares++;
    end
    drive(1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
    bus.tapSel = 2'd0; #1;
    vectors++;
    if (bus.fillCount !== 3'd4 || bus.wordOut !== 8'h05 || bus.tapOut !== 8'h02) begin
      $display("FAIL rev_saturate: got cnt %0d out %0h tap0 %0h expected 4 05 02",
               bus.fillCount, bus.wordOut, bus.tapOut); miscompares++;
    end
  endtask

  task automatic test_dir_change();
    apply_reset(1);
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    // stage0=22 stage1=11 -> reverse 33: stage0=11 stage3=33, 22 dropped
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
    bus.tapSel = 2'd0; #1;
    vectors++;
    if (bus.fillCount !== 3'd2 || bus.wordOut !== 8'h33 || bus.tapOut !== 8'h11) begin
      $display("FAIL dirchg_rev1: got cnt %0d out %0h tap0 %0h expected 2 33 11",
               bus.fillCount, bus.wordOut, bus.tapOut); miscompares++;
    end
    // reverse 44: 11 falls off stage0, count unchanged
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
    bus.tapSel = 2'd2; #1;
    vectors++;
    if (bus.fillCount !== 3'd2 || bus.wordOut !== 8'h44 || bus.tapOut !== 8'h33) begin
      $display("FAIL dirchg_rev2: got cnt %0d out %0h tap2 %0h expected 2 44 33",
               bus.fillCount, bus.wordOut, bus.tapOut); miscompares++;
    end
  endtask

  task automatic test_clear();
    apply_reset(1);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 8'h10 + 8'(k), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    bus.clear = 1'b0;
    bus.shiftEnable = 1'b0;
    vectors++;
    if (bus.fillCount !== 3'd0 || bus.full !== 1'b0 || bus.wordOut !== 8'h00 || bus.wordValid !== 1'b0) begin
      $display("FAIL clear_status: got cnt %0d full %0b out %0h val %0b expected 0 0 00 0",
               bus.fillCount, bus.full, bus.wordOut, bus.wordValid); miscompares++;
    end
    for (int t = 0; t < 4; t++) begin
      bus.tapSel = 2'(t);
      #1;
      vectors++;
      if (bus.tapOut !== 8'h00) begin
        $display("FAIL clear_tap%0d: got %0h expected 00", t, bus.tapOut); miscompares++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset(1);
    drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    vectors++;
    if (bus.fillCount !== 3'd2) begin
      $display("FAIL mid_pre_fillCount: got %0d expected 2", bus.fillCount); miscompares++;
    end
    apply_reset(1);
    bus.tapSel = 2'd1; #1;
    vectors++;
    if (bus.fillCount !== 3'd0 || bus.wordOut !== 8'h00 || bus.tapOut !== 8'h00) begin
      $display("FAIL mid_reset: got cnt %0d out %0h tap1 %0h expected 0 00 00",
               bus.fillCount, bus.wordOut, bus.tapOut); miscompares++;
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 8'(k), 1'b0, 1'b0);
      vectors++;
      if (k < 4 && bus.wordValid !== 1'b0) begin
        $display("FAIL mid_stale_valid shift%0d: got %0b expected 0", k, bus.wordValid); miscompares++;
      end else if (k == 4 && (bus.wordOut !== 8'h01 || bus.wordValid !== 1'b1)) begin
        $display("FAIL mid_wordOut: got %0h/%0b expected 01/1", bus.wordOut, bus.wordValid); miscompares++;
      end
    end
  endtask

  task automatic test_rotate();
`ifdef SHREG_ROTATE_EN
    logic [7:0] exp_out [4] = '{8'h02, 8'h03, 8'h04, 8'h01};
`else
    logic [7:0] exp_out [4] = '{8'h02, 8'h03, 8'h04, 8'hE0};
`endif
    apply_reset(1);
    for (int k = 1; k <= 4; k++) drive(1'b1, 1'b0, 8'(k), 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b0, 8'hE0 + 8'(r), 1'b0, 1'b1);
      vectors++;
      if (bus.wordOut !== exp_out[r] || bus.fillCount !== 3'd4) begin
        $display("FAIL rotate edge%0d: got out %0h cnt %0d expected %0h 4",
                 r + 1, bus.wordOut, bus.fillCount, exp_out[r]); miscompares++;
      end
    end
    bus.rotate = 1'b0;
    bus.shiftEnable = 1'b0;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.shiftEnable = 1'b0;
    bus.dir         = 1'b0;
    bus.clear       = 1'b0;
    bus.rotate      = 1'b0;
    bus.wordIn      = 8'h00;
    bus.tapSel      = 2'd0;
    @(negedge clk);

    test_reset();
    test_forward_fill();
    test_gaps();
    test_reverse();
    test_dir_change();
    test_clear();
    test_reset_midstream();
    test_rotate();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
